// File: rtl/warp_imem.sv
// warp_imem: instruction-memory responder for the fetch unit.
// Reads are accepted every cycle. The array is read when the request is accepted.
// Data and valid then pass through LATENCY-1 further register stages, so the
// response appears a fixed LATENCY cycles later. Responses stay in request order.
// A flush kills every in-flight response. The request presented in the flush
// cycle is still accepted and returns normally.
// Optional feature: define WARP_IMEM_FAULT_EN to add o_imem_fault. This flag
// follows valid and marks responses to out-of-range addresses.
// Parameters: BASE_ADDR is the byte address of index 0. DEPTH is a power of two
// and at least 2. LATENCY is between 1 and 8.
module warp_imem #(
  parameter logic [38:0] BASE_ADDR = 39'h4000000000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_ren,
  input  logic [38:0] i_imem_raddr,
  input  logic        i_flush,
  input  logic        i_wen,
  input  logic [38:0] i_waddr,
  input  logic [63:0] i_wdata,
  input  logic [7:0]  i_wstrb,
  output logic        o_imem_valid,
  output logic [63:0] o_imem_rdata
`ifdef WARP_IMEM_FAULT_EN
  ,
  output logic        o_imem_fault
`endif
);

  localparam int          IW   = $clog2(DEPTH);
  // Size of the mapped window in bytes. Offsets at or above this value miss the array.
  localparam logic [38:0] SPAN = 39'(DEPTH) << 3;

  logic [63:0]        mem [DEPTH];

  logic [38:0]        rd_off;
  logic               rd_in_range;
  logic [IW-1:0]      rd_idx;
  logic [63:0]        rd_data_d;

  logic [38:0]        wr_off;
  logic               wr_in_range;
  logic [IW-1:0]      wr_idx;

  logic [LATENCY-1:0] vld_q;
  logic [63:0]        data_q [LATENCY];
`ifdef WARP_IMEM_FAULT_EN
  logic [LATENCY-1:0] flt_q;
`endif

  // Decode the read address and read the array at acceptance (out of range reads as zero).
  always_comb begin
    rd_off      = i_imem_raddr - BASE_ADDR;
    // The full offset is compared, so a wrap below BASE_ADDR cannot alias into the array.
    rd_in_range = (i_imem_raddr >= BASE_ADDR) && (rd_off < SPAN);
    rd_idx      = rd_off[IW+2:3];
    rd_data_d   = rd_in_range ? mem[rd_idx] : '0;
  end

  // Decode the preload write address. Writes outside the window are dropped.
  always_comb begin
    wr_off      = i_waddr - BASE_ADDR;
    wr_in_range = (i_waddr >= BASE_ADDR) && (wr_off < SPAN);
    wr_idx      = wr_off[IW+2:3];
  end

  // Byte-masked preload write. A read on the same edge still sees the old contents.
  // NOTE: the array has no reset branch. Resetting it would turn the RAM into
  // flops, and boot code must survive a fetch-side reset anyway.
  always_ff @(posedge i_clk) begin
    if (i_wen && wr_in_range) begin
      for (int b = 0; b < 8; b++) begin
        if (i_wstrb[b]) mem[wr_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Response shift pipeline. Data stages only load behind a surviving valid,
  // so the output data holds its value while valid is low.
  // NOTE: non-blocking assignments let every stage sample its neighbour's
  // pre-edge value. Blocking assignments would collapse the pipeline into one stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) data_q[k] <= '0;
    end else begin
      vld_q[0] <= i_imem_ren;
      if (i_imem_ren) data_q[0] <= rd_data_d;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1] & ~i_flush;
        if (vld_q[k-1] && !i_flush) data_q[k] <= data_q[k-1];
      end
    end
  end

`ifdef WARP_IMEM_FAULT_EN
  // The fault flag moves in lockstep with valid and is killed by flush the same way.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      flt_q <= '0;
    end else begin
      flt_q[0] <= i_imem_ren & ~rd_in_range;
      for (int k = 1; k < LATENCY; k++) begin
        flt_q[k] <= flt_q[k-1] & vld_q[k-1] & ~i_flush;
      end
    end
  end

  assign o_imem_fault = flt_q[LATENCY-1];
`endif

  assign o_imem_valid = vld_q[LATENCY-1];
  assign o_imem_rdata = data_q[LATENCY-1];

endmodule

// File: tb/tb_warp_imem.sv
// tb_warp_imem: directed test of warp_imem with the default parameters.
// Each request pushes an expected response, tagged with its due cycle, onto a
// queue. A negedge monitor compares what the DUT returns against the front of
// that queue.
module tb_warp_imem;

  localparam logic [38:0] BASE  = 39'h4000000000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam int          IW    = $clog2(DEPTH);

  typedef struct {
    int          due;
    logic [63:0] data;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ren = 1'b0;
  logic [38:0] raddr = '0;
  logic        flush = 1'b0;
  logic        wen = 1'b0;
  logic [38:0] waddr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        valid;
  logic [63:0] rdata;
`ifdef WARP_IMEM_FAULT_EN
  logic        fault;
`endif

  exp_t        sb [$];
  logic [63:0] model [DEPTH];
  logic [63:0] last_rdata = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  warp_imem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_imem_ren   (ren),
    .i_imem_raddr (raddr),
    .i_flush      (flush),
    .i_wen        (wen),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .i_wstrb      (wstrb),
    .o_imem_valid (valid),
    .o_imem_rdata (rdata)
`ifdef WARP_IMEM_FAULT_EN
    ,
    .o_imem_fault (fault)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_rng(input logic [38:0] a);
    logic [39:0] lo, hi;
    lo = {1'b0, BASE};
    hi = {1'b0, BASE} + 40'(DEPTH) * 40'd8;
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  function automatic int idx_of(input logic [38:0] a);
    logic [39:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    return int'(off[IW+2:3]);
  endfunction

  // One clock of stimulus. The expected read result comes from the model
  // before this edge's write is applied, so the model is read-first.
  task automatic step(input logic r, input logic [38:0] ra, input logic w,
                      input logic [38:0] wa, input logic [63:0] wd,
                      input logic [7:0] ws, input logic f);
    exp_t e;
    if (f) begin
      while (sb.size() > 0 && sb[$].due >= cyc + 1) void'(sb.pop_back());
    end
    if (r) begin
      e.due = cyc + LAT;
      if (in_rng(ra)) begin
        e.data  = model[idx_of(ra)];
        e.fault = 1'b0;
      end else begin
        e.data  = '0;
        e.fault = 1'b1;
      end
      sb.push_back(e);
    end
    if (w && in_rng(wa)) begin
      for (int b = 0; b < 8; b++)
        if (ws[b]) model[idx_of(wa)][8*b +: 8] = wd[8*b +: 8];
    end
    ren = r; raddr = ra; wen = w; waddr = wa; wdata = wd; wstrb = ws; flush = f;
    @(posedge clk);
    #1;
    ren = 1'b0; wen = 1'b0; flush = 1'b0; wstrb = '0;
  endtask

  task automatic rd(input logic [38:0] a);
    step(1'b1, a, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [38:0] a, input logic [63:0] d, input logic [7:0] s);
    step(1'b0, '0, 1'b1, a, d, s, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Response monitor: checks the due cycle, the data, and data hold while idle.
  always @(negedge clk) begin
    if (valid) begin
      checks++;
      assert (sb.size() > 0 && sb[0].due == cyc) else begin
        errors++;
        $error("FAIL resp_timing: valid at cycle %0d, expected due %0d (queue %0d)",
               cyc, (sb.size() > 0) ? sb[0].due : -1, sb.size());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        checks++;
        assert (rdata === sb[0].data) else begin
          errors++;
          $error("FAIL resp_data: got %h expected %h at cycle %0d", rdata, sb[0].data, cyc);
        end
`ifdef WARP_IMEM_FAULT_EN
        checks++;
        assert (fault === sb[0].fault) else begin
          errors++;
          $error("FAIL resp_fault: got %b expected %b at cycle %0d", fault, sb[0].fault, cyc);
        end
`endif
        void'(sb.pop_front());
      end
      last_rdata = rdata;
    end else begin
      checks++;
      assert (!(sb.size() > 0 && sb[0].due == cyc)) else begin
        errors++;
        $error("FAIL resp_missing: valid=%b expected 1 at cycle %0d", valid, cyc);
        void'(sb.pop_front());
      end
      checks++;
      assert (rdata === last_rdata) else begin
        errors++;
        $error("FAIL rdata_hold: got %h expected %h at cycle %0d", rdata, last_rdata, cyc);
      end
    end
  end

  initial begin
    // Outputs must already be cleared while reset is held.
    #1;
    checks++;
    assert (valid === 1'b0) else begin
      errors++; $error("FAIL reset_valid: got %b expected 0", valid);
    end
    checks++;
    assert (rdata === 64'h0) else begin
      errors++; $error("FAIL reset_rdata: got %h expected 0", rdata);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Preload one doubleword, then read it back.
    wr(39'h4000000008, 64'h0011223344556677, 8'hFF);
    rd(39'h4000000008);
    idle(3);

    // Streaming: four back-to-back reads return four back-to-back responses.
    wr(39'h4000000000, 64'd1, 8'hFF);
    wr(39'h4000000008, 64'd2, 8'hFF);
    wr(39'h4000000010, 64'd3, 8'hFF);
    wr(39'h4000000018, 64'd4, 8'hFF);
    rd(39'h4000000000);
    rd(39'h4000000008);
    rd(39'h4000000010);
    rd(39'h4000000018);
    idle(3);

    // Byte strobe plus a read/write collision on index 5.
    wr(BASE + 39'd40, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    wr(BASE + 39'd56, 64'hC0DE_7777_0000_0007, 8'hFF);
    step(1'b1, BASE + 39'd40, 1'b1, BASE + 39'd40, 64'h0, 8'h0F, 1'b0);
    rd(BASE + 39'd40);
    wr(BASE + 39'd72, 64'hABCD_EF01_2345_6789, 8'h81);
    rd(BASE + 39'd72);
    idle(3);

    // Flush: in-flight responses not yet shown are killed, and the idx 7 read survives.
    rd(BASE + 39'd0);
    rd(BASE + 39'd8);
    step(1'b1, BASE + 39'd56, 1'b0, '0, '0, '0, 1'b1);
    idle(4);

    // Out of range: below BASE and one past the end. The write past the end must not alias to index 0.
    rd(39'h3FFFFFFFF8);
    rd(BASE + 39'(DEPTH) * 39'd8);
    wr(BASE + 39'(DEPTH) * 39'd8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    wr(39'h3FFFFFFFF8, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
    wr(BASE + 39'(DEPTH - 1) * 39'd8, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    rd(BASE);
    rd(BASE + 39'(DEPTH - 1) * 39'd8);
    idle(3);

    // Reset lands between edges with two requests in flight.
    rd(BASE + 39'd16);
    rd(BASE + 39'd24);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    assert (valid === 1'b0) else begin
      errors++; $error("FAIL midreset_valid: got %b expected 0", valid);
    end
    checks++;
    assert (rdata === 64'h0) else begin
      errors++; $error("FAIL midreset_rdata: got %h expected 0", rdata);
    end
    sb.delete();
    last_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    rd(BASE + 39'd16);
    rd(BASE + 39'd24);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
